// File: rtl/bin2bcd_pipe_pkg.sv
// Shared definitions for the bin2BCD pipeline register chain.
// Holds the default word width and the occupancy-counter width helper.
package bin2bcd_pipe_pkg;

  localparam int WORD_LENGTH_DEF = 6;

  // Bits needed to count 0..depth stored words.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a data register.
// Flush clears the valid bit only. Bubbles never overwrite held data.
module pipe_stage
  import bin2bcd_pipe_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   valid_in,
  input  logic [WORD_LENGTH-1:0] data_in,
  output logic                   valid_out,
  output logic [WORD_LENGTH-1:0] data_out
);

  // Slot state: flush beats load, and data is written only for real words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (load) begin
      valid_out <= valid_in;
      if (valid_in) data_out <= data_in;
    end
  end

endmodule

// File: rtl/pipe_register_chain.sv
// DEPTH-deep chain of enabled registers with a valid/ready handshake on both
// ends, bubble collapsing and synchronous flush.
// Optional build macro PIPE_OCCUPANCY_EN adds a registered occupancy count.
module pipe_register_chain
  import bin2bcd_pipe_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_LENGTH-1:0]      Data_Input,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef PIPE_OCCUPANCY_EN
  output logic [occ_w(DEPTH)-1:0]     occupancy,
`endif
  output logic [WORD_LENGTH-1:0]      Data_Output
);

  logic [DEPTH-1:0]                  vld_pipe;
  logic [DEPTH-1:0]                  adv;
  logic [DEPTH-1:0]                  up_vld;
  logic [DEPTH-1:0][WORD_LENGTH-1:0] data_pipe;
  logic [DEPTH-1:0][WORD_LENGTH-1:0] up_data;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      // A stage may advance if the output drains or any slot from here to the
      // output is empty; written flat so the ready path has no bit loop.
      assign adv[i] = out_ready | ~(&vld_pipe[DEPTH-1:i]);

      if (i == 0) begin : g_head
        assign up_vld[i]  = in_valid & in_ready;
        assign up_data[i] = Data_Input;
      end else begin : g_body
        assign up_vld[i]  = vld_pipe[i-1];
        assign up_data[i] = data_pipe[i-1];
      end

      pipe_stage #(.WORD_LENGTH(WORD_LENGTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .load      (adv[i]),
        .valid_in  (up_vld[i]),
        .data_in   (up_data[i]),
        .valid_out (vld_pipe[i]),
        .data_out  (data_pipe[i])
      );
    end
  endgenerate

  assign in_ready    = adv[0] & ~flush;
  assign out_valid   = vld_pipe[DEPTH-1];
  assign Data_Output = data_pipe[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_w(DEPTH);

  logic in_xfer, out_xfer;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Word count tracks transfers, so it moves on the same edge as the valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     occupancy <= '0;
    else if (flush) occupancy <= '0;
    else            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end
`endif

endmodule

// File: tb/tb_pipe_register_chain.sv
// Self-checking bench for pipe_register_chain (DEPTH=3, WORD_LENGTH=6).
// Model: an ordered queue of in-flight words with their slot positions.
module tb_pipe_register_chain;

  localparam int W = 6;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] din;
  logic         in_ready, out_valid;
  logic [W-1:0] dout;
`ifdef PIPE_OCCUPANCY_EN
  logic [$clog2(D+1)-1:0] occ;
`endif

  pipe_register_chain #(.WORD_LENGTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Data_Input  (din),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef PIPE_OCCUPANCY_EN
    .occupancy   (occ),
`endif
    .Data_Output (dout)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] d;
    int           p;
  } word_t;

  word_t        mq[$];
  logic [W-1:0] m_last = '0;

  logic [W-1:0] got[$];
  int           got_cyc[$];
  int           cyc = 0;
  int           first_in = -1;
  int           first_out = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ovld();
    return (mq.size() > 0) && (mq[0].p == D - 1);
  endfunction

  // Space exists unless all slots are full and the consumer is stalled.
  function automatic bit m_irdy();
    return !flush && ((mq.size() < D) || out_ready);
  endfunction

  // Model step: oldest word leaves if offered and taken; every other word
  // slides one slot if the slot ahead ends up free; a new word enters slot 0.
  task automatic model_step();
    bit    ox, ix;
    int    lim;
    word_t w;
    ox = m_ovld() && out_ready;
    ix = in_valid && m_irdy();
    if (ox) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
      return;
    end
    lim = D;
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].p + 1 < lim) mq[k].p = mq[k].p + 1;
      lim = mq[k].p;
    end
    if (ix) begin
      w.d = din;
      w.p = 0;
      mq.push_back(w);
    end
    if (m_ovld()) m_last = mq[0].d;
  endtask

  always @(posedge clk) if (reset === 1'b1) model_step();

  always @(negedge reset) begin
    mq.delete();
    m_last = '0;
  end

  // Compare process: every cycle, inputs settled, before the next edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    check("out_valid", out_valid, m_ovld());
    check("in_ready", in_ready, m_irdy());
    check("data_out", dout, m_last);
`ifdef PIPE_OCCUPANCY_EN
    check("occupancy", occ, mq.size());
`endif
    if (reset && in_valid && in_ready && first_in < 0) first_in = cyc;
    if (reset && out_valid && first_out < 0) first_out = cyc;
    if (reset && out_valid && out_ready) begin
      got.push_back(dout);
      got_cyc.push_back(cyc);
    end
  end

  task automatic drv(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    first_in  = -1;
    first_out = -1;
  endtask

  task automatic chk_seq(input string nm, input logic [W-1:0] e[$]);
    check({nm, "_count"}, got.size(), e.size());
    for (int k = 0; k < e.size() && k < got.size(); k++)
      check(nm, got[k], e[k]);
  endtask

  initial begin
    logic [W-1:0] e[$];
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", dout, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;

    // Streaming, no backpressure.
    clear_log();
    drv(1, 6'h01, 1, 0);
    drv(1, 6'h02, 1, 0);
    drv(1, 6'h03, 1, 0);
    drv(1, 6'h04, 1, 0);
    repeat (6) drv(0, 6'h00, 1, 0);
    e = '{6'h01, 6'h02, 6'h03, 6'h04};
    chk_seq("stream", e);
    check("stream_latency", first_out - first_in, D);
    if (got_cyc.size() == 4) check("stream_gapless", got_cyc[3] - got_cyc[0], 3);
    else check("stream_gapless_count", got_cyc.size(), 4);

    // Backpressure fill, then drain.
    clear_log();
    drv(1, 6'h0A, 0, 0);
    drv(1, 6'h0B, 0, 0);
    drv(1, 6'h0C, 0, 0);
    drv(1, 6'h0D, 0, 0);
    #2 check("bp_full_in_ready", in_ready, 0);
    drv(1, 6'h0D, 1, 0);
    #2 check("bp_shift_in_ready", in_ready, 1);
    repeat (6) drv(0, 6'h00, 1, 0);
    e = '{6'h0A, 6'h0B, 6'h0C, 6'h0D};
    chk_seq("backpressure", e);

    // Bubble collapse against a stalled output.
    clear_log();
    drv(1, 6'h11, 0, 0);
    drv(0, 6'h00, 0, 0);
    drv(1, 6'h12, 0, 0);
    drv(0, 6'h00, 0, 0);
    drv(0, 6'h00, 0, 0);
    #2;
    check("bubble_out_valid", out_valid, 1);
    check("bubble_head", dout, 6'h11);
    check("bubble_in_ready", in_ready, 1);
`ifdef PIPE_OCCUPANCY_EN
    check("bubble_occ", occ, 2);
`endif
    repeat (4) drv(0, 6'h00, 1, 0);
    e = '{6'h11, 6'h12};
    chk_seq("bubble", e);

    // Full chain: shift one out and accept one in on the same edge.
    clear_log();
    drv(1, 6'h21, 0, 0);
    drv(1, 6'h22, 0, 0);
    drv(1, 6'h23, 0, 0);
    drv(0, 6'h00, 0, 0);
    #2 check("full_in_ready", in_ready, 0);
    drv(1, 6'h3F, 1, 0);
    #2;
    check("shift_in_ready", in_ready, 1);
    check("shift_head", dout, 6'h21);
    drv(0, 6'h00, 0, 0);
    #2;
    check("shift_next_head", dout, 6'h22);
`ifdef PIPE_OCCUPANCY_EN
    check("shift_occ", occ, 3);
`endif
    repeat (5) drv(0, 6'h00, 1, 0);
    e = '{6'h21, 6'h22, 6'h23, 6'h3F};
    chk_seq("shift", e);

    // Flush with two words held and an input offered.
    clear_log();
    drv(1, 6'h05, 0, 0);
    drv(1, 6'h06, 0, 0);
    drv(0, 6'h00, 0, 0);
    drv(0, 6'h00, 0, 0);
    drv(1, 6'h2A, 0, 1);
    #2 check("flush_in_ready", in_ready, 0);
    drv(0, 6'h00, 1, 0);
    #2;
    check("flush_out_valid", out_valid, 0);
    check("flush_data_hold", dout, 6'h05);
`ifdef PIPE_OCCUPANCY_EN
    check("flush_occ", occ, 0);
`endif
    repeat (5) drv(0, 6'h00, 1, 0);
    check("flush_nothing_out", got.size(), 0);

    // Asynchronous reset mid-stream.
    drv(1, 6'h07, 0, 0);
    drv(1, 6'h08, 0, 0);
    drv(0, 6'h00, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data_out", dout, 0);
    check("mid_rst_in_ready", in_ready, 1);
`ifdef PIPE_OCCUPANCY_EN
    check("mid_rst_occ", occ, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    drv(1, 6'h15, 1, 0);
    repeat (5) drv(0, 6'h00, 1, 0);
    e = '{6'h15};
    chk_seq("post_reset", e);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
